// File: rtl/pipe_skid16.sv
// ============================================================================
// pipe_skid16 : two-entry skid buffer with registered in_ready/out_valid.
// Optional macro PIPE_SKID_FLUSH_EN adds a synchronous flush input.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pipe_skid16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  // State encoding doubles as the word count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             flush_w;
  logic             in_xfer;
  logic             out_xfer;

`ifdef PIPE_SKID_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d = state;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush only drops the state; stale data is unobservable once EMPTY.
    if (flush_w) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid16.sv
// ============================================================================
// tb_pipe_skid16 : randomized and directed checks of pipe_skid16 against a
// queue-based reference model. Revision 1.0
// ============================================================================
`default_nettype none

module tb_pipe_skid16;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [1:0]       occupancy;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model_q[$];
  bit               hold_pending = 1'b0;
  logic [WIDTH-1:0] hold_data = '0;

  pipe_skid16 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef PIPE_SKID_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: compare DUT with the model mid-cycle, then advance the model.
  task automatic step();
    bit ix;
    bit ox;
    @(negedge clk);
    check("in_ready", {31'd0, in_ready}, (model_q.size() < 2) ? 32'd1 : 32'd0);
    check("out_valid", {31'd0, out_valid}, (model_q.size() > 0) ? 32'd1 : 32'd0);
    check("occupancy", {30'd0, occupancy}, model_q.size());
    if (model_q.size() > 0) check("out_data", {16'd0, out_data}, {16'd0, model_q[0]});
    if (hold_pending) check("stable", {16'd0, out_data}, {16'd0, hold_data});
    ix = in_valid && (model_q.size() < 2);
    ox = out_ready && (model_q.size() > 0);
    hold_pending = rst_n && !flush && (model_q.size() > 0) && !out_ready;
    if (model_q.size() > 0) hold_data = model_q[0];
    @(posedge clk);
    if (!rst_n || flush) begin
      model_q.delete();
    end else begin
      if (ox) void'(model_q.pop_front());
      if (ix) model_q.push_back(in_data);
    end
    #1;
  endtask

  initial begin
    // Initial reset without model checks (DUT state unknown before it).
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_occ", {30'd0, occupancy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // Single word, one-cycle latency.
    in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("lat_data", {16'd0, out_data}, 32'h1234);
    check("lat_occ", {30'd0, occupancy}, 32'd1);
    step();
    check("drain_occ", {30'd0, occupancy}, 32'd0);

    // Backpressure fills the skid register.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hA001; step();
    in_data = 16'hA002; step();
    in_valid = 1'b0; in_data = 16'hDEAD;
    check("full_occ", {30'd0, occupancy}, 32'd2);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_data", {16'd0, out_data}, 32'hA001);
    in_valid = 1'b1; step();
    in_valid = 1'b0;
    check("full_hold", {16'd0, out_data}, 32'hA001);
    out_ready = 1'b1;
    step();
    check("pop1_data", {16'd0, out_data}, 32'hA002);
    check("pop1_occ", {30'd0, occupancy}, 32'd1);
    step();
    check("pop2_occ", {30'd0, occupancy}, 32'd0);

    // Streaming at full rate.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = WIDTH'(i);
      step();
      check("stream_data", {16'd0, out_data}, i);
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 1);
      in_data   = WIDTH'($urandom);
      step();
    end

    // Reset while full discards contents.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'hB001; step();
    in_data = 16'hB002; step();
    in_data = 16'hB003; step();
    check("pre_rst_occ", {30'd0, occupancy}, 32'd2);
    rst_n = 1'b0; out_ready = 1'b1;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    check("mid_rst_occ", {30'd0, occupancy}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();

`ifdef PIPE_SKID_FLUSH_EN
    // Flush while busy drops the word being pushed alongside it.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hC001; step();
    in_data = 16'hC002; flush = 1'b1; step();
    flush = 1'b0;
    check("flush_occ", {30'd0, occupancy}, 32'd0);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    in_data = 16'h00FF; step();
    in_valid = 1'b0;
    check("flush_next_data", {16'd0, out_data}, 32'h00FF);
    check("flush_next_occ", {30'd0, occupancy}, 32'd1);
    out_ready = 1'b1; step();
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
